link_id_tx: RTL and testbench

LINK_ID_TX -- requirements
Module: link_id_tx

---
 rtl/link_id_tx_if.sv | 41 ++++
 rtl/link_id_tx.sv | 211 +++++++++++++++++++++
 tb/tb_link_id_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_id_tx_if.sv
// ---------------------------------------------------------------------------
// link_id_tx_if -- signal bundle for the link_id_tx packet transmitter.
// Carries the ID-load port, the start strobe, the upstream body-word
// handshake (I_Valid/I_Term/I_Data against O_Nack), the downstream word
// handshake (O_Valid/O_Hdr/O_Term/O_Data against I_Nack) and O_Busy.
//   master : the side that loads IDs, starts packets, feeds body words and
//            applies downstream back-pressure.
//   slave  : the transmitter itself.
// ---------------------------------------------------------------------------
interface link_id_tx_if #(
  parameter int WIDTH_DATA = 32
);

  logic                  I_Ld_ID;
  logic [1:0]            I_Sel_ID;
  logic [WIDTH_DATA-1:0] I_ID;
  logic                  I_Start;
  logic                  I_Valid;
  logic                  I_Term;
  logic [WIDTH_DATA-1:0] I_Data;
  logic                  O_Nack;
  logic                  O_Valid;
  logic                  O_Hdr;
  logic                  O_Term;
  logic [WIDTH_DATA-1:0] O_Data;
  logic                  I_Nack;
  logic                  O_Busy;

  modport master (
    output I_Ld_ID, I_Sel_ID, I_ID, I_Start,
    output I_Valid, I_Term, I_Data, I_Nack,
    input  O_Nack, O_Valid, O_Hdr, O_Term, O_Data, O_Busy
  );

  modport slave (
    input  I_Ld_ID, I_Sel_ID, I_ID, I_Start,
    input  I_Valid, I_Term, I_Data, I_Nack,
    output O_Nack, O_Valid, O_Hdr, O_Term, O_Data, O_Busy
  );

endinterface

// File: rtl/link_id_tx.sv
// ---------------------------------------------------------------------------
// link_id_tx -- packet transmitter that prefixes a body with ID header words.
//
// A packet is: My-ID, T-ID, [F-ID], then body words buffered in a small FIFO
// until the word flagged Term has been sent. ID registers can only be loaded
// while idle (INIT). Every output is decoded from flops only, so there is no
// combinational path from any input to any output.
//
// Build option: define LINK_ID_TX_FID_EN to add the third header word (F-ID)
// and its register. Without it the header is My-ID, T-ID only and F-ID loads
// are dropped.
//
// DEPTH_FIFO must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module link_id_tx #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH_FIFO = 4
) (
  input  logic         clock,
  input  logic         reset,
  link_id_tx_if.slave  lnk
);

  localparam int AW = $clog2(DEPTH_FIFO);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_SEND_MY_ID = 3'd1,
    ST_SEND_T_ID  = 3'd2,
`ifdef LINK_ID_TX_FID_EN
    ST_SEND_F_ID  = 3'd3,
`endif
    ST_BODY       = 3'd4,
    ST_TERM       = 3'd5
  } state_t;

  typedef struct packed {
    logic                  term;
    logic [WIDTH_DATA-1:0] data;
  } entry_t;

  state_t                state_q;
  logic [WIDTH_DATA-1:0] my_id_q;
  logic [WIDTH_DATA-1:0] t_id_q;
`ifdef LINK_ID_TX_FID_EN
  logic [WIDTH_DATA-1:0] f_id_q;
`endif
  logic                  term_in_q;   // Term word already accepted this packet

  entry_t                mem_q [DEPTH_FIFO];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic                  in_body;
  logic                  full;
  logic                  empty;
  logic                  nack;
  logic                  push;
  logic                  pop;
  entry_t                head;

  logic                  o_valid;
  logic                  o_hdr;
  logic                  o_term;
  logic [WIDTH_DATA-1:0] o_data;

  assign in_body = (state_q == ST_BODY);
  assign full    = (count_q == CW'(DEPTH_FIFO));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // Upstream back-pressure uses only registered state, so a full FIFO never
  // sees a same-cycle push-and-pop.
  assign nack = !in_body || full || term_in_q;
  assign push = in_body && lnk.I_Valid && !nack;
  assign pop  = in_body && !empty && !lnk.I_Nack;

  // Occupancy next value: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control FSM plus ID registers; header words advance only on transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q   <= ST_INIT;
      my_id_q   <= '0;
      t_id_q    <= '0;
`ifdef LINK_ID_TX_FID_EN
      f_id_q    <= '0;
`endif
      term_in_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (lnk.I_Ld_ID) begin
            case (lnk.I_Sel_ID)
              2'd0:    my_id_q <= lnk.I_ID;
              2'd1:    t_id_q  <= lnk.I_ID;
`ifdef LINK_ID_TX_FID_EN
              2'd2:    f_id_q  <= lnk.I_ID;
`endif
              default: ;
            endcase
          end
          if (lnk.I_Start) state_q <= ST_SEND_MY_ID;
        end
        ST_SEND_MY_ID: begin
          if (!lnk.I_Nack) state_q <= ST_SEND_T_ID;
        end
        ST_SEND_T_ID: begin
`ifdef LINK_ID_TX_FID_EN
          if (!lnk.I_Nack) state_q <= ST_SEND_F_ID;
`else
          if (!lnk.I_Nack) state_q <= ST_BODY;
`endif
        end
`ifdef LINK_ID_TX_FID_EN
        ST_SEND_F_ID: begin
          if (!lnk.I_Nack) state_q <= ST_BODY;
        end
`endif
        ST_BODY: begin
          if (push && lnk.I_Term) term_in_q <= 1'b1;
          if (pop && head.term)   state_q   <= ST_TERM;
        end
        ST_TERM: begin
          term_in_q <= 1'b0;
          state_q   <= ST_INIT;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // FIFO pointers and occupancy; cleared by reset so a packet cut short by
  // reset leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and count_q alone decides what is valid.
    if (push) mem_q[wr_ptr_q] <= '{term: lnk.I_Term, data: lnk.I_Data};
  end

  // Downstream word decode: header registers in SEND states, FIFO head in BODY.
  always_comb begin
    o_valid = 1'b0;
    o_hdr   = 1'b0;
    o_term  = 1'b0;
    o_data  = '0;
    case (state_q)
      ST_SEND_MY_ID: begin
        o_valid = 1'b1;
        o_hdr   = 1'b1;
        o_data  = my_id_q;
      end
      ST_SEND_T_ID: begin
        o_valid = 1'b1;
        o_hdr   = 1'b1;
        o_data  = t_id_q;
      end
`ifdef LINK_ID_TX_FID_EN
      ST_SEND_F_ID: begin
        o_valid = 1'b1;
        o_hdr   = 1'b1;
        o_data  = f_id_q;
      end
`endif
      ST_BODY: begin
        if (!empty) begin
          o_valid = 1'b1;
          o_term  = head.term;
          o_data  = head.data;
        end
      end
      default: ;
    endcase
  end

  assign lnk.O_Valid = o_valid;
  assign lnk.O_Hdr   = o_hdr;
  assign lnk.O_Term  = o_term;
  assign lnk.O_Data  = o_data;
  assign lnk.O_Nack  = nack;
  assign lnk.O_Busy  = (state_q != ST_INIT);

endmodule

// File: tb/tb_link_id_tx.sv
// ---------------------------------------------------------------------------
// tb_link_id_tx -- directed self-checking bench for link_id_tx.
// Expected header length follows LINK_ID_TX_FID_EN the same way the design
// build does. Downstream transfers are captured on the falling edge and
// compared against hand-built expected word lists.
// ---------------------------------------------------------------------------
module tb_link_id_tx;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  link_id_tx_if #(.WIDTH_DATA(W)) lnk ();

  link_id_tx #(.WIDTH_DATA(W), .DEPTH_FIFO(4)) dut (
    .clock (clock),
    .reset (reset),
    .lnk   (lnk)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Each captured word is {hdr, term, data}.
  logic [W+1:0] obs_q [$];
  logic [W+1:0] exp_q [$];
  bit           term_seen = 1'b0;

  // Record every word that transfers on the following rising edge.
  always @(negedge clock) begin
    if (reset && lnk.O_Valid && !lnk.I_Nack) begin
      obs_q.push_back({lnk.O_Hdr, lnk.O_Term, lnk.O_Data});
      if (lnk.O_Term) term_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    lnk.I_Ld_ID  = 1'b0;
    lnk.I_Sel_ID = 2'd0;
    lnk.I_ID     = '0;
    lnk.I_Start  = 1'b0;
    lnk.I_Valid  = 1'b0;
    lnk.I_Term   = 1'b0;
    lnk.I_Data   = '0;
    lnk.I_Nack   = 1'b0;
  endtask

  task automatic load_id(input logic [1:0] sel, input logic [W-1:0] val);
    lnk.I_Ld_ID  = 1'b1;
    lnk.I_Sel_ID = sel;
    lnk.I_ID     = val;
    step();
    lnk.I_Ld_ID  = 1'b0;
  endtask

  task automatic start_pkt();
    lnk.I_Start = 1'b1;
    step();
    lnk.I_Start = 1'b0;
  endtask

  // Offer one body word and hold it until the transmitter accepts it.
  task automatic send_body(input logic [W-1:0] data, input logic term);
    bit ok = 1'b0;
    lnk.I_Valid = 1'b1;
    lnk.I_Data  = data;
    lnk.I_Term  = term;
    for (int i = 0; i < 50; i++) begin
      if (!lnk.O_Nack) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    lnk.I_Valid = 1'b0;
    lnk.I_Term  = 1'b0;
    if (!ok) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_body();
    for (int i = 0; i < 20 && lnk.O_Nack; i++) step();
    check("body_reached", lnk.O_Nack, 64'd0);
  endtask

  // Returns in the cycle right after the Term word transferred (TERM state).
  task automatic wait_term();
    for (int i = 0; i < 60 && !term_seen; i++) step();
    check("term_seen", term_seen, 64'd1);
  endtask

  task automatic check_term_exit();
    check("term_busy", lnk.O_Busy, 64'd1);
    check("term_valid", lnk.O_Valid, 64'd0);
    step();
    check("init_busy", lnk.O_Busy, 64'd0);
    check("init_nack", lnk.O_Nack, 64'd1);
  endtask

  task automatic exp_hdr(input logic [W-1:0] my, input logic [W-1:0] t, input logic [W-1:0] f);
    exp_q.push_back({2'b10, my});
    exp_q.push_back({2'b10, t});
`ifdef LINK_ID_TX_FID_EN
    exp_q.push_back({2'b10, f});
`else
    if (f != f) exp_q.push_back('0);
`endif
  endtask

  task automatic exp_body(input logic [W-1:0] data, input logic term);
    exp_q.push_back({1'b0, term, data});
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    term_seen = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (2) step();
    // Reset state.
    check("rst_valid", lnk.O_Valid, 64'd0);
    check("rst_hdr",   lnk.O_Hdr,   64'd0);
    check("rst_term",  lnk.O_Term,  64'd0);
    check("rst_data",  lnk.O_Data,  64'd0);
    check("rst_busy",  lnk.O_Busy,  64'd0);
    check("rst_nack",  lnk.O_Nack,  64'd1);
    reset = 1'b1;
    step();

    // Basic packet: three ID loads plus an ignored select 3.
    load_id(2'd0, 32'h11);
    load_id(2'd1, 32'h22);
    load_id(2'd2, 32'h33);
    load_id(2'd3, 32'h44);
    start_pkt();
    check("my_busy", lnk.O_Busy,  64'd1);
    check("my_data", lnk.O_Data,  64'h11);
    check("my_hdr",  lnk.O_Hdr,   64'd1);
    check("my_nack", lnk.O_Nack,  64'd1);
    send_body(32'hA0, 1'b0);
    send_body(32'hA1, 1'b1);
    wait_term();
    check_term_exit();
    exp_hdr(32'h11, 32'h22, 32'h33);
    exp_body(32'hA0, 1'b0);
    exp_body(32'hA1, 1'b1);
    check_seq("basic");

    // Downstream stall on T-ID; ID load and start in mid-packet are ignored.
    start_pkt();
    step();
    lnk.I_Nack   = 1'b1;
    lnk.I_Ld_ID  = 1'b1;
    lnk.I_Sel_ID = 2'd0;
    lnk.I_ID     = 32'h99;
    lnk.I_Start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_valid%0d", i), lnk.O_Valid, 64'd1);
      check($sformatf("stall_data%0d", i),  lnk.O_Data,  64'h22);
      check($sformatf("stall_hdr%0d", i),   lnk.O_Hdr,   64'd1);
      step();
      lnk.I_Ld_ID = 1'b0;
      lnk.I_Start = 1'b0;
    end
    lnk.I_Nack = 1'b0;
    send_body(32'hA0, 1'b0);
    send_body(32'hA1, 1'b1);
    wait_term();
    check_term_exit();
    step();
    check("no_restart_busy", lnk.O_Busy, 64'd0);
    exp_hdr(32'h11, 32'h22, 32'h33);
    exp_body(32'hA0, 1'b0);
    exp_body(32'hA1, 1'b1);
    check_seq("stall");

    // FIFO fill under continuous downstream back-pressure.
    start_pkt();
    wait_body();
    lnk.I_Nack = 1'b1;
    for (int i = 0; i < 4; i++) send_body(32'hB0 + W'(i), 1'b0);
    check("full_nack",  lnk.O_Nack,  64'd1);
    check("full_valid", lnk.O_Valid, 64'd1);
    check("full_head",  lnk.O_Data,  64'hB0);
    repeat (2) step();
    check("full_hold",  lnk.O_Data,  64'hB0);
    lnk.I_Nack = 1'b0;
    send_body(32'hB4, 1'b1);
    wait_term();
    check_term_exit();
    exp_hdr(32'h11, 32'h22, 32'h33);
    for (int i = 0; i < 4; i++) exp_body(32'hB0 + W'(i), 1'b0);
    exp_body(32'hB4, 1'b1);
    check_seq("fill");

    // Simultaneous push and pop with two entries held.
    start_pkt();
    wait_body();
    lnk.I_Nack = 1'b1;
    send_body(32'hD0, 1'b0);
    send_body(32'hD1, 1'b0);
    check("pp_count_init", dut.count_q, 64'd2);
    lnk.I_Nack = 1'b0;
    for (int k = 2; k < 7; k++) begin
      lnk.I_Valid = 1'b1;
      lnk.I_Term  = 1'b0;
      lnk.I_Data  = 32'hD0 + W'(k);
      check($sformatf("pp_nack%0d", k), lnk.O_Nack, 64'd0);
      step();
      check($sformatf("pp_count%0d", k), dut.count_q, 64'd2);
    end
    lnk.I_Valid = 1'b0;
    send_body(32'hD7, 1'b1);
    wait_term();
    check_term_exit();
    exp_hdr(32'h11, 32'h22, 32'h33);
    for (int i = 0; i < 7; i++) exp_body(32'hD0 + W'(i), 1'b0);
    exp_body(32'hD7, 1'b1);
    check_seq("pushpop");

    // Reset in mid-packet after the second body word.
    start_pkt();
    wait_body();
    send_body(32'hA0, 1'b0);
    send_body(32'hA1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_valid", lnk.O_Valid, 64'd0);
    check("mrst_hdr",   lnk.O_Hdr,   64'd0);
    check("mrst_term",  lnk.O_Term,  64'd0);
    check("mrst_data",  lnk.O_Data,  64'd0);
    check("mrst_busy",  lnk.O_Busy,  64'd0);
    step();
    reset = 1'b1;
    obs_q.delete();
    term_seen = 1'b0;
    repeat (8) step();
    check("mrst_no_words", obs_q.size(), 64'd0);
    check("mrst_idle",     lnk.O_Busy,   64'd0);
    check("mrst_nack",     lnk.O_Nack,   64'd1);

    // ID registers read back as zero after reset.
    start_pkt();
    send_body(32'hC0, 1'b1);
    wait_term();
    check_term_exit();
    exp_hdr(32'h0, 32'h0, 32'h0);
    exp_body(32'hC0, 1'b1);
    check_seq("zero_id");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
